// File: rtl/core_pkg.sv
// core_pkg: shared AXI response codes, instruction ARPROT and fetch buffer entry type
package core_pkg;
  localparam int CORE_XLEN = 32;
  localparam logic [2:0] ARPROT_INSTR = 3'b100;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
  typedef struct packed {
    logic [CORE_XLEN-1:0] data;
    logic [CORE_XLEN-1:0] pc;
    logic                 fault;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and simultaneous push/pop when full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based multi-outstanding instruction fetch with prefetch FIFO and redirect flush
module fetch_unit import core_pkg::*; #(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_fault,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  output logic [2:0]      o_im_arprot,
  input  logic            i_im_rvalid,
  output logic            o_im_rready,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic [1:0]      i_im_rresp
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, ret_pc, redirect_pc, next_pc;
  logic [CW-1:0] outstanding, discard, fifo_count, out_nxt, sum_nxt;
  logic stale_ar, held, ar_fire, r_fire, drop, push, pop, launch, fifo_empty, fifo_full;
  fetch_entry_t push_entry, head;
  assign redirect_pc = i_redirect_pc & ~XLEN'(3);
  assign next_pc = i_redirect_valid ? redirect_pc : fetch_pc;
  assign held = o_im_arvalid & ~i_im_arready;
  assign ar_fire = o_im_arvalid & i_im_arready;
  assign r_fire = i_im_rvalid & (outstanding != '0);
  assign drop = i_redirect_valid | (discard != '0);
  assign push = r_fire & ~drop & (~fifo_full | pop);
  assign pop = o_inst_valid & i_inst_ready & ~i_redirect_valid;
  assign out_nxt = outstanding + CW'(ar_fire) - CW'(r_fire);
  assign sum_nxt = i_redirect_valid ? '0 : fifo_count + outstanding - discard + CW'(ar_fire) - CW'(pop);
  assign launch = (sum_nxt < CW'(DEPTH)) & (out_nxt < CW'(DEPTH));
  assign push_entry = '{data: i_im_rdata, pc: ret_pc, fault: axi_resp_e'(i_im_rresp) != RESP_OKAY};
  assign o_inst_valid = ~fifo_empty;
  assign o_inst_data = head.data;
  assign o_inst_pc = head.pc;
  assign o_inst_fault = head.fault;
  assign o_im_arprot = ARPROT_INSTR;
  assign o_im_rready = 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      ret_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      stale_ar <= 1'b0;
      o_im_arvalid <= 1'b0;
      o_im_araddr <= RESET_PC;
    end else begin
      outstanding <= out_nxt;
      discard <= i_redirect_valid ? out_nxt
               : discard - CW'(r_fire && discard != '0) + CW'(ar_fire && stale_ar);
      stale_ar <= i_redirect_valid ? held : stale_ar & ~ar_fire;
      ret_pc <= i_redirect_valid ? redirect_pc : ret_pc + ((r_fire && !drop) ? XLEN'(4) : '0);
      o_im_arvalid <= held | launch;
      fetch_pc <= (!held && launch) ? next_pc + XLEN'(4) : next_pc;
      if (!held && launch) o_im_araddr <= next_pc;
    end
  end
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .flush    (i_redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a sequential-stream memory model
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
  logic clk = 0, rst = 1;
  logic i_redirect_valid = 0;
  logic [31:0] i_redirect_pc = 0;
  logic o_inst_valid, i_inst_ready = 0, o_inst_fault;
  logic [31:0] o_inst_data, o_inst_pc;
  logic o_im_arvalid, i_im_arready = 0, i_im_rvalid = 0, o_im_rready;
  logic [31:0] o_im_araddr, i_im_rdata = 0;
  logic [2:0] o_im_arprot;
  logic [1:0] i_im_rresp = 0;
  int checks = 0, fails = 0, pops = 0, ar_count = 0;
  int ar_mode = 0, r_prob = 100, r_budget = -1;
  typedef struct { logic [31:0] pc, data; logic fault; } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] exp_tail, arq[$];
  logic [31:0] exp_ar = RESET_PC, prev_addr = 0;
  logic ar_skip = 0, prev_held = 0, prev_redirect = 0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready), .o_inst_data(o_inst_data),
    .o_inst_pc(o_inst_pc), .o_inst_fault(o_inst_fault), .o_im_arvalid(o_im_arvalid),
    .i_im_arready(i_im_arready), .o_im_araddr(o_im_araddr), .o_im_arprot(o_im_arprot),
    .i_im_rvalid(i_im_rvalid), .o_im_rready(o_im_rready), .i_im_rdata(i_im_rdata),
    .i_im_rresp(i_im_rresp)
  );

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic mem_fault(logic [31:0] a);
    return a == 32'h108 || (a[9:2] % 23) == 7;
  endfunction
  function automatic logic [1:0] mem_resp(logic [31:0] a);
    return mem_fault(a) ? (a[2] ? 2'b11 : 2'b10) : 2'b00;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_stream(logic [31:0] pc);
    exp_q.delete();
    exp_tail = pc;
    repeat (8) begin
      exp_q.push_back('{exp_tail, mem_data(exp_tail), mem_fault(exp_tail)});
      exp_tail += 4;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    set_stream(RESET_PC);
    @(negedge clk);
    @(negedge clk);
    check("rst_inst_valid", o_inst_valid, 0);
    check("rst_arvalid", o_im_arvalid, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic redirect(logic [31:0] pc);
    @(posedge clk); #1;
    i_redirect_valid = 1;
    i_redirect_pc = pc | 32'($urandom_range(0, 3));
    set_stream(pc & ~32'h3);
    @(posedge clk); #1;
    i_redirect_valid = 0;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    @(negedge clk);
    while (!o_inst_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, o_inst_valid, 1);
  endtask

  task automatic count_gaps(string name, int cycles);
    int gaps = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (!o_inst_valid) gaps++;
    end
    check(name, gaps, 0);
  endtask

  // Scoreboard monitor: every accepted instruction must be the next word of the current stream
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_redirect) check("valid_after_redirect", o_inst_valid, 0);
      if (o_inst_valid && i_inst_ready && !i_redirect_valid) begin
        cur = exp_q.pop_front();
        check("inst_pc", o_inst_pc, cur.pc);
        check("inst_data", o_inst_data, cur.data);
        check("inst_fault", o_inst_fault, cur.fault);
        exp_q.push_back('{exp_tail, mem_data(exp_tail), mem_fault(exp_tail)});
        exp_tail += 4;
        pops++;
      end
    end
    prev_redirect = i_redirect_valid && !rst;
  end

  // Memory slave: records accepted ARs, returns them in order, checks AR ordering and stability
  initial forever begin
    @(negedge clk);
    if (rst) begin
      arq.delete();
      exp_ar = RESET_PC;
      ar_skip = 0;
      prev_held = 0;
    end else begin
      check("rready", o_im_rready, 1);
      if (prev_held) begin
        check("ar_hold_valid", o_im_arvalid, 1);
        check("ar_hold_addr", o_im_araddr, prev_addr);
      end
      if (i_im_rvalid) begin
        void'(arq.pop_front());
        if (r_budget > 0) r_budget--;
      end
      if (o_im_arvalid && i_im_arready) begin
        ar_count++;
        if (ar_skip) ar_skip = 0;
        else begin
          check("ar_addr", o_im_araddr, exp_ar);
          exp_ar += 4;
        end
        arq.push_back(o_im_araddr);
      end
      if (i_redirect_valid) begin
        exp_ar = i_redirect_pc & ~32'h3;
        ar_skip = ar_skip | (o_im_arvalid && !i_im_arready);
      end
      check("outstanding_bound", arq.size() <= DEPTH, 1);
      prev_held = o_im_arvalid && !i_im_arready;
      prev_addr = o_im_araddr;
    end
    @(posedge clk); #1;
    i_im_arready = ar_mode == 0 ? 1'b1 : ar_mode == 2 ? 1'b0 : ($urandom_range(0, 9) < 7);
    if (!rst && arq.size() > 0 && r_budget != 0 && $urandom_range(0, 99) < r_prob) begin
      i_im_rvalid = 1;
      i_im_rdata = mem_data(arq[0]);
      i_im_rresp = mem_resp(arq[0]);
    end else i_im_rvalid = 0;
  end

  initial begin
    logic rd;
    logic [31:0] tgt;
    int base;
    do_reset();
    check("arprot", o_im_arprot, 3'b100);
    // streaming through the faulting word at 0x108, then reset mid-stream
    i_inst_ready = 1;
    do_reset();
    wait_valid("stream_first_valid");
    check("stream_first_pc", o_inst_pc, RESET_PC);
    count_gaps("stream_gaps", 30);
    do_reset();
    wait_valid("restart_valid");
    check("restart_pc", o_inst_pc, RESET_PC);
    repeat (10) @(negedge clk);
    // backpressure
    i_inst_ready = 0;
    do_reset();
    base = ar_count;
    repeat (20) @(negedge clk);
    check("bp_ar_count", ar_count - base, DEPTH);
    check("bp_valid", o_inst_valid, 1);
    @(posedge clk); #1;
    i_inst_ready = 1;
    count_gaps("bp_drain_gaps", 16);
    // redirect with three reads in flight and one word buffered
    i_inst_ready = 0;
    do_reset();
    r_budget = 1;
    repeat (10) @(negedge clk);
    check("inflight3", arq.size(), 3);
    check("buffered_pc", o_inst_pc, RESET_PC);
    r_budget = -1;
    redirect(32'h2000);
    i_inst_ready = 1;
    wait_valid("redir_valid");
    check("redir_first_pc", o_inst_pc, 32'h2000);
    repeat (20) @(negedge clk);
    // redirect while AR stalled
    ar_mode = 2;
    do_reset();
    repeat (4) @(negedge clk);
    check("stall_arvalid", o_im_arvalid, 1);
    check("stall_araddr", o_im_araddr, RESET_PC);
    redirect(32'h2000);
    repeat (4) @(negedge clk);
    ar_mode = 0;
    wait_valid("stall_redir_valid");
    check("stall_redir_pc", o_inst_pc, 32'h2000);
    repeat (20) @(negedge clk);
    // random traffic including address wrap and back-to-back redirects
    ar_mode = 1;
    r_prob = 60;
    redirect(32'hFFFFFFF8);
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      i_inst_ready = $urandom_range(0, 3) != 0;
      rd = ($urandom_range(0, 39) == 0) || (i_redirect_valid && $urandom_range(0, 1) == 1);
      if (rd) begin
        tgt = $urandom;
        i_redirect_pc = tgt;
        set_stream(tgt & ~32'h3);
      end
      i_redirect_valid = rd;
    end
    @(posedge clk); #1;
    i_redirect_valid = 0;
    repeat (20) @(negedge clk);
    check("min_instructions", pops > 150, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
